// File: rtl/dvp_frame_tx.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// dvp_frame_tx
//
// Purpose
//   Source end of an OV5640-style DVP camera bus. Pulls RGB565 pixels over a
//   valid/ready handshake and replays them as vsync / href / 8-bit data, two
//   bytes per pixel, high byte first. Frame timing is free-running once a
//   frame starts: the transmitter never waits for pixels. A missing pixel
//   becomes 16'h0000 on the bus and sets a sticky underflow flag.
//
//   Frame layout (one frame, in clock cycles):
//     VSYNC  (VS_CYC)  -> VBACK (VBP_CYC) ->
//     { LINE (2*H_PIXEL, href=1) -> HBLANK (H_BLANK) } x V_PIXEL ->
//     VFRONT (VFP_CYC) -> next VSYNC if enable, else IDLE.
//
// Ports
//   clk          pixel/byte clock, all logic on the rising edge
//   rst          asynchronous reset, active-high
//   enable       start/continue frames; looked at only in IDLE and on the
//                last VFRONT cycle
//   pix_data     RGB565 pixel {R[4:0],G[5:0],B[4:0]}
//   pix_valid    pix_data is valid
//   pix_ready    pixel accepted this cycle (decoded from state only)
//   dvp_vsync    frame sync, equals VSYNC_POL while asserted
//   dvp_href     line valid
//   dvp_data     byte bus, 8'h00 whenever dvp_href is low
//   frame_start  one-cycle pulse on the first asserted vsync cycle
//   frame_done   one-cycle pulse on the last VFRONT cycle
//   underflow    sticky: a pixel slot passed with pix_valid low
// -----------------------------------------------------------------------------
module dvp_frame_tx #(
    parameter int   H_PIXEL   = 640,
    parameter int   V_PIXEL   = 480,
    parameter int   H_BLANK   = 144,
    parameter int   VS_CYC    = 1600,
    parameter int   VBP_CYC   = 1600,
    parameter int   VFP_CYC   = 800,
    parameter logic VSYNC_POL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [15:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic        dvp_vsync,
    output logic        dvp_href,
    output logic [7:0]  dvp_data,
    output logic        frame_start,
    output logic        frame_done,
    output logic        underflow
);

    // ------------------------------------------------------------------
    // Counter sizing
    // ------------------------------------------------------------------
    localparam int BYTES_PER_LINE = 2 * H_PIXEL;
    localparam int BYTE_W = (BYTES_PER_LINE > 1) ? $clog2(BYTES_PER_LINE) : 1;
    localparam int LINE_W = (V_PIXEL > 1) ? $clog2(V_PIXEL) : 1;

    // One shared blank counter serves VSYNC, VBACK, HBLANK and VFRONT, so it
    // must reach the longest of them.
    localparam int MAX_A     = (VS_CYC > VBP_CYC) ? VS_CYC : VBP_CYC;
    localparam int MAX_B     = (VFP_CYC > H_BLANK) ? VFP_CYC : H_BLANK;
    localparam int BLANK_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int BLANK_W   = (BLANK_MAX > 1) ? $clog2(BLANK_MAX) : 1;

    localparam logic [BLANK_W-1:0] VS_LAST  = BLANK_W'(VS_CYC - 1);
    localparam logic [BLANK_W-1:0] VBP_LAST = BLANK_W'(VBP_CYC - 1);
    localparam logic [BLANK_W-1:0] HB_LAST  = BLANK_W'(H_BLANK - 1);
    localparam logic [BLANK_W-1:0] VFP_LAST = BLANK_W'(VFP_CYC - 1);
    localparam logic [BYTE_W-1:0]  BYTE_LAST = BYTE_W'(BYTES_PER_LINE - 1);
    localparam logic [LINE_W-1:0]  LINE_LAST = LINE_W'(V_PIXEL - 1);

    // Inside a line, the low-byte cycle of pixel k requests pixel k+1. The
    // last such cycle is the low byte of pixel H_PIXEL-2, at byte index
    // 2*H_PIXEL-3. With a single pixel per line there is no in-line request.
    localparam bit                LINE_REQ_EN   = (H_PIXEL > 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST_REQ = BYTE_W'((H_PIXEL > 1) ? (BYTES_PER_LINE - 3) : 0);

    // ------------------------------------------------------------------
    // FSM encoding
    // ------------------------------------------------------------------
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_VSYNC  = 3'd1;
    localparam logic [2:0] ST_VBACK  = 3'd2;
    localparam logic [2:0] ST_LINE   = 3'd3;
    localparam logic [2:0] ST_HBLANK = 3'd4;
    localparam logic [2:0] ST_VFRONT = 3'd5;

    logic [2:0]         state_q,  state_d;
    logic [BLANK_W-1:0] blank_q,  blank_d;
    logic [BYTE_W-1:0]  byte_q,   byte_d;
    logic [LINE_W-1:0]  line_q,   line_d;

    logic [7:0]  lo_q,          lo_d;
    logic        vsync_q,       vsync_d;
    logic        href_q,        href_d;
    logic [7:0]  data_q,        data_d;
    logic        frame_start_q, frame_start_d;
    logic        frame_done_q,  frame_done_d;
    logic        underflow_q,   underflow_d;

    // Pixel as seen on a transfer slot: an empty slot reads as zero.
    logic [15:0] pix_slot;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_slot
            assign pix_slot[gi] = pix_data[gi] & pix_valid;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Next-state and counter logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        blank_d = blank_q;
        byte_d  = byte_q;
        line_d  = line_q;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_VSYNC;
                    blank_d = '0;
                end
            end

            ST_VSYNC: begin
                if (blank_q == VS_LAST) begin
                    state_d = ST_VBACK;
                    blank_d = '0;
                end else begin
                    blank_d = blank_q + BLANK_W'(1);
                end
            end

            ST_VBACK: begin
                if (blank_q == VBP_LAST) begin
                    state_d = ST_LINE;
                    blank_d = '0;
                    byte_d  = '0;
                end else begin
                    blank_d = blank_q + BLANK_W'(1);
                end
            end

            ST_LINE: begin
                if (byte_q == BYTE_LAST) begin
                    state_d = ST_HBLANK;
                    byte_d  = '0;
                    blank_d = '0;
                end else begin
                    byte_d = byte_q + BYTE_W'(1);
                end
            end

            ST_HBLANK: begin
                if (blank_q == HB_LAST) begin
                    blank_d = '0;
                    if (line_q == LINE_LAST) begin
                        state_d = ST_VFRONT;
                        line_d  = '0;
                    end else begin
                        state_d = ST_LINE;
                        line_d  = line_q + LINE_W'(1);
                        byte_d  = '0;
                    end
                end else begin
                    blank_d = blank_q + BLANK_W'(1);
                end
            end

            ST_VFRONT: begin
                if (blank_q == VFP_LAST) begin
                    blank_d = '0;
                    // Back-to-back frames: straight into VSYNC, no idle gap.
                    state_d = enable ? ST_VSYNC : ST_IDLE;
                end else begin
                    blank_d = blank_q + BLANK_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                blank_d = '0;
                byte_d  = '0;
                line_d  = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pixel request: the cycle before each pixel's high byte hits the bus.
    // ------------------------------------------------------------------
    always_comb begin
        pix_ready = 1'b0;
        case (state_q)
            ST_VBACK:  pix_ready = (blank_q == VBP_LAST);
            // The blank after the final line leads to VFRONT, not a new line.
            ST_HBLANK: pix_ready = (blank_q == HB_LAST) && (line_q != LINE_LAST);
            ST_LINE:   pix_ready = LINE_REQ_EN && byte_q[0] && (byte_q <= BYTE_LAST_REQ);
            default:   pix_ready = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Registered outputs, computed from the next state so each output lines
    // up with the state it describes.
    // ------------------------------------------------------------------
    always_comb begin
        // Only the low byte needs holding: the high byte goes straight to the
        // bus on the transfer edge.
        lo_d = pix_ready ? pix_slot[7:0] : lo_q;

        vsync_d = (state_d == ST_VSYNC) ? VSYNC_POL : ~VSYNC_POL;
        href_d  = (state_d == ST_LINE);

        data_d = 8'h00;
        if (state_d == ST_LINE) begin
            // An even next byte is always preceded by a transfer cycle, so
            // the incoming slot supplies it directly.
            data_d = byte_d[0] ? lo_q : pix_slot[15:8];
        end

        frame_start_d = (state_d == ST_VSYNC) && (state_q != ST_VSYNC);
        frame_done_d  = (state_d == ST_VFRONT) && (blank_d == VFP_LAST);

        underflow_d = underflow_q | (pix_ready & ~pix_valid);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            blank_q       <= '0;
            byte_q        <= '0;
            line_q        <= '0;
            lo_q          <= 8'h00;
            vsync_q       <= ~VSYNC_POL;
            href_q        <= 1'b0;
            data_q        <= 8'h00;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            blank_q       <= blank_d;
            byte_q        <= byte_d;
            line_q        <= line_d;
            lo_q          <= lo_d;
            vsync_q       <= vsync_d;
            href_q        <= href_d;
            data_q        <= data_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            underflow_q   <= underflow_d;
        end
    end

    assign dvp_vsync   = vsync_q;
    assign dvp_href    = href_q;
    assign dvp_data    = data_q;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;
    assign underflow   = underflow_q;

endmodule

// File: tb/tb_dvp_frame_tx.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_dvp_frame_tx
//
// Two transmitters share all inputs: one with active-high vsync, one with
// active-low vsync. A per-cycle monitor walks a frame-position model and a
// byte scoreboard (expected bytes queued when a pixel slot is offered,
// popped while href is high). Scenario tasks add their own targeted checks.
// -----------------------------------------------------------------------------
module tb_dvp_frame_tx;

    localparam int H_PIXEL   = 4;
    localparam int V_PIXEL   = 2;
    localparam int H_BLANK   = 3;
    localparam int VS_CYC    = 2;
    localparam int VBP_CYC   = 3;
    localparam int VFP_CYC   = 2;
    localparam int LINE_LEN  = 2 * H_PIXEL + H_BLANK;              // 11
    localparam int ACT_START = VS_CYC + VBP_CYC;                   // 5
    localparam int FRAME_LEN = ACT_START + V_PIXEL * LINE_LEN + VFP_CYC; // 29

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] pix_data;
    logic        pix_valid;

    logic        pix_ready,   pix_ready_n;
    logic        dvp_vsync,   dvp_vsync_n;
    logic        dvp_href,    dvp_href_n;
    logic [7:0]  dvp_data,    dvp_data_n;
    logic        frame_start, frame_start_n;
    logic        frame_done,  frame_done_n;
    logic        underflow,   underflow_n;

    dvp_frame_tx #(
        .H_PIXEL(H_PIXEL), .V_PIXEL(V_PIXEL), .H_BLANK(H_BLANK),
        .VS_CYC(VS_CYC), .VBP_CYC(VBP_CYC), .VFP_CYC(VFP_CYC), .VSYNC_POL(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .dvp_vsync(dvp_vsync), .dvp_href(dvp_href), .dvp_data(dvp_data),
        .frame_start(frame_start), .frame_done(frame_done), .underflow(underflow)
    );

    dvp_frame_tx #(
        .H_PIXEL(H_PIXEL), .V_PIXEL(V_PIXEL), .H_BLANK(H_BLANK),
        .VS_CYC(VS_CYC), .VBP_CYC(VBP_CYC), .VFP_CYC(VFP_CYC), .VSYNC_POL(1'b0)
    ) dut_n (
        .clk(clk), .rst(rst), .enable(enable),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready_n),
        .dvp_vsync(dvp_vsync_n), .dvp_href(dvp_href_n), .dvp_data(dvp_data_n),
        .frame_start(frame_start_n), .frame_done(frame_done_n), .underflow(underflow_n)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Scoreboard and monitor state
    logic [7:0] exp_q[$];
    bit mon_en     = 1'b0;
    bit in_frame   = 1'b0;
    bit advance    = 1'b0;
    bit last_valid = 1'b0;
    int p          = 0;
    int ready_cnt  = 0;
    int drop_slot  = 0;

    // Frame-position reference (position 0 = first vsync cycle)
    function automatic logic f_vsync(int pos);
        return (pos < VS_CYC);
    endfunction

    function automatic logic f_href(int pos);
        int q;
        q = pos - ACT_START;
        if (q < 0 || q >= V_PIXEL * LINE_LEN) return 1'b0;
        return ((q % LINE_LEN) < 2 * H_PIXEL);
    endfunction

    function automatic logic f_ready(int pos);
        int q, o, l;
        if (pos == ACT_START - 1) return 1'b1;
        q = pos - ACT_START;
        if (q < 0 || q >= V_PIXEL * LINE_LEN) return 1'b0;
        o = q % LINE_LEN;
        l = q / LINE_LEN;
        if (o < 2 * H_PIXEL) return ((o % 2) == 1) && (o < 2 * H_PIXEL - 2);
        return (o == LINE_LEN - 1) && (l < V_PIXEL - 1);
    endfunction

    // ------------------------------------------------------------------
    // Pixel driver + monitor + scoreboard, one step per falling edge
    // ------------------------------------------------------------------
    initial begin
        logic       ev, eh, er, ed;
        logic [7:0] eb;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                // Present the next pixel once the previous slot has gone.
                if (advance) begin
                    advance = 1'b0;
                    if (last_valid) pix_data = pix_data + 16'h2222;
                    pix_valid = ((ready_cnt + 1) != drop_slot);
                end

                if (in_frame) p++;
                if (frame_start === 1'b1) begin
                    if (in_frame) begin
                        tests_run++;
                        if (p !== FRAME_LEN) begin
                            tests_failed++;
                            $display("FAIL frame_period: got %0d expected %0d", p, FRAME_LEN);
                        end
                    end
                    p = 0;
                    in_frame = 1'b1;
                end else if (in_frame && p >= FRAME_LEN) begin
                    in_frame = 1'b0;
                end

                if (in_frame) begin
                    ev = f_vsync(p);
                    eh = f_href(p);
                    er = f_ready(p);
                    ed = (p == FRAME_LEN - 1);
                end else begin
                    ev = 1'b0; eh = 1'b0; er = 1'b0; ed = 1'b0;
                end

                tests_run++;
                if (dvp_vsync !== ev || dvp_vsync_n !== ~ev) begin
                    tests_failed++;
                    $display("FAIL vsync: got %b/%b expected %b/%b at p=%0d", dvp_vsync, dvp_vsync_n, ev, ~ev, p);
                end
                tests_run++;
                if (dvp_href !== eh || dvp_href_n !== eh) begin
                    tests_failed++;
                    $display("FAIL href: got %b/%b expected %b at p=%0d", dvp_href, dvp_href_n, eh, p);
                end
                tests_run++;
                if (pix_ready !== er || pix_ready_n !== er) begin
                    tests_failed++;
                    $display("FAIL pix_ready: got %b/%b expected %b at p=%0d", pix_ready, pix_ready_n, er, p);
                end
                tests_run++;
                if (frame_done !== ed || frame_done_n !== ed) begin
                    tests_failed++;
                    $display("FAIL frame_done: got %b/%b expected %b at p=%0d", frame_done, frame_done_n, ed, p);
                end
                tests_run++;
                if (frame_start !== (in_frame && p == 0) || frame_start_n !== frame_start) begin
                    tests_failed++;
                    $display("FAIL frame_start: got %b/%b expected %b at p=%0d", frame_start, frame_start_n, (in_frame && p == 0), p);
                end

                if (eh) begin
                    tests_run++;
                    if (exp_q.size() == 0) begin
                        tests_failed++;
                        $display("FAIL data_sb_empty: got %02h with no byte expected at p=%0d", dvp_data, p);
                    end else begin
                        eb = exp_q.pop_front();
                        if (dvp_data !== eb || dvp_data_n !== eb) begin
                            tests_failed++;
                            $display("FAIL data: got %02h/%02h expected %02h at p=%0d", dvp_data, dvp_data_n, eb, p);
                        end
                    end
                end else begin
                    tests_run++;
                    if (dvp_data !== 8'h00 || dvp_data_n !== 8'h00) begin
                        tests_failed++;
                        $display("FAIL data_idle: got %02h/%02h expected 00 at p=%0d", dvp_data, dvp_data_n, p);
                    end
                end

                // A slot offered now transfers on the coming rising edge.
                if (pix_ready === 1'b1) begin
                    ready_cnt++;
                    last_valid = pix_valid;
                    if (pix_valid) begin
                        exp_q.push_back(pix_data[15:8]);
                        exp_q.push_back(pix_data[7:0]);
                    end else begin
                        exp_q.push_back(8'h00);
                        exp_q.push_back(8'h00);
                    end
                    advance = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset;
        rst = 1'b1; enable = 1'b0; pix_valid = 1'b0; pix_data = 16'h0000;
        mon_en = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (dvp_vsync !== 1'b0 || dvp_vsync_n !== 1'b1 || dvp_href !== 1'b0 || dvp_data !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_bus: got vs=%b vsn=%b href=%b data=%02h expected 0 1 0 00", dvp_vsync, dvp_vsync_n, dvp_href, dvp_data);
        end
        tests_run++;
        if (pix_ready !== 1'b0 || frame_start !== 1'b0 || frame_done !== 1'b0 || underflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: got rdy=%b fs=%b fd=%b uf=%b expected all 0", pix_ready, frame_start, frame_done, underflow);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (dvp_vsync !== 1'b0 || frame_start !== 1'b0 || pix_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_no_enable: got vs=%b fs=%b rdy=%b expected 0 0 0", dvp_vsync, frame_start, pix_ready);
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_frames;
        int fs_cnt, fd_cnt, rdy_cnt, href_cnt, vs_cnt, first_href;
        fs_cnt = 0; fd_cnt = 0; rdy_cnt = 0; href_cnt = 0; vs_cnt = 0; first_href = -1;
        exp_q.delete();
        pix_data = 16'hA1B2; pix_valid = 1'b1;
        ready_cnt = 0; drop_slot = 0; advance = 1'b0; in_frame = 1'b0;
        mon_en = 1'b1;
        enable = 1'b1;
        @(negedge clk);
        tests_run++;
        if (frame_start !== 1'b1) begin
            tests_failed++;
            $display("FAIL start_latency: got frame_start=%b expected 1", frame_start);
        end
        for (int i = 0; i < 2 * FRAME_LEN; i++) begin
            if (frame_start) fs_cnt++;
            if (frame_done)  fd_cnt++;
            if (pix_ready)   rdy_cnt++;
            if (dvp_vsync)   vs_cnt++;
            if (dvp_href) begin
                href_cnt++;
                if (first_href < 0) first_href = i;
            end
            if (i == FRAME_LEN - 1) begin
                tests_run++;
                if (exp_q.size() != 0) begin
                    tests_failed++;
                    $display("FAIL sb_drain: got %0d bytes pending expected 0", exp_q.size());
                end
            end
            @(negedge clk);
        end
        tests_run++;
        if (fs_cnt != 2 || fd_cnt != 2) begin
            tests_failed++;
            $display("FAIL pulse_count: got fs=%0d fd=%0d expected 2 2", fs_cnt, fd_cnt);
        end
        tests_run++;
        if (rdy_cnt != 2 * V_PIXEL * H_PIXEL) begin
            tests_failed++;
            $display("FAIL ready_count: got %0d expected %0d", rdy_cnt, 2 * V_PIXEL * H_PIXEL);
        end
        tests_run++;
        if (href_cnt != 2 * V_PIXEL * 2 * H_PIXEL || vs_cnt != 2 * VS_CYC) begin
            tests_failed++;
            $display("FAIL href_vsync_count: got href=%0d vs=%0d expected %0d %0d", href_cnt, vs_cnt, 4 * V_PIXEL * H_PIXEL, 2 * VS_CYC);
        end
        tests_run++;
        if (first_href != ACT_START) begin
            tests_failed++;
            $display("FAIL first_href: got %0d expected %0d", first_href, ACT_START);
        end
        tests_run++;
        if (frame_start !== 1'b1) begin
            tests_failed++;
            $display("FAIL back_to_back: got frame_start=%b expected 1", frame_start);
        end
        $display("[TB] test_frames done: fs=%0d fd=%0d ready=%0d href=%0d", fs_cnt, fd_cnt, rdy_cnt, href_cnt);
    endtask

    task automatic test_underflow;
        int fs_cnt;
        fs_cnt = 0;
        for (int i = 0; i < FRAME_LEN + 2 && frame_start !== 1'b1; i++) @(negedge clk);
        tests_run++;
        if (frame_start !== 1'b1) begin
            tests_failed++;
            $display("FAIL uf_wait_start: got timeout expected frame_start");
        end
        tests_run++;
        if (underflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL uf_before: got %b expected 0", underflow);
        end
        ready_cnt = 0;
        drop_slot = 3;
        repeat (8) @(negedge clk);     // p=8: third slot offered now
        tests_run++;
        if (pix_ready !== 1'b1 || underflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL uf_slot: got rdy=%b uf=%b expected 1 0", pix_ready, underflow);
        end
        @(negedge clk);
        tests_run++;
        if (underflow !== 1'b1 || underflow_n !== 1'b1) begin
            tests_failed++;
            $display("FAIL uf_set: got %b/%b expected 1", underflow, underflow_n);
        end
        drop_slot = 0;
        for (int i = 0; i < FRAME_LEN; i++) begin
            @(negedge clk);
            if (frame_start) fs_cnt++;
        end
        tests_run++;
        if (underflow !== 1'b1 || fs_cnt != 1) begin
            tests_failed++;
            $display("FAIL uf_sticky: got uf=%b fs=%0d expected 1 1", underflow, fs_cnt);
        end
        $display("[TB] test_underflow done");
    endtask

    task automatic test_enable_stop;
        int fs_cnt, fd_cnt;
        fs_cnt = 0; fd_cnt = 0;
        for (int i = 0; i < FRAME_LEN + 2 && frame_start !== 1'b1; i++) @(negedge clk);
        for (int i = 0; i < FRAME_LEN && dvp_href !== 1'b1; i++) @(negedge clk);
        tests_run++;
        if (dvp_href !== 1'b1) begin
            tests_failed++;
            $display("FAIL stop_wait_line: got timeout expected href");
        end
        enable = 1'b0;
        for (int i = 0; i < FRAME_LEN + 10; i++) begin
            @(negedge clk);
            if (frame_start) fs_cnt++;
            if (frame_done)  fd_cnt++;
        end
        tests_run++;
        if (fd_cnt != 1 || fs_cnt != 0) begin
            tests_failed++;
            $display("FAIL stop_pulses: got fd=%0d fs=%0d expected 1 0", fd_cnt, fs_cnt);
        end
        tests_run++;
        if (dvp_vsync !== 1'b0 || dvp_vsync_n !== 1'b1 || dvp_href !== 1'b0) begin
            tests_failed++;
            $display("FAIL stop_idle: got vs=%b vsn=%b href=%b expected 0 1 0", dvp_vsync, dvp_vsync_n, dvp_href);
        end
        enable = 1'b1;
        @(negedge clk);
        tests_run++;
        if (frame_start !== 1'b1 || dvp_vsync !== 1'b1) begin
            tests_failed++;
            $display("FAIL restart: got fs=%b vs=%b expected 1 1", frame_start, dvp_vsync);
        end
        $display("[TB] test_enable_stop done");
    endtask

    task automatic test_reset_mid;
        int fd_at;
        fd_at = -1;
        for (int i = 0; i < FRAME_LEN && dvp_href !== 1'b1; i++) @(negedge clk);
        mon_en = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (dvp_vsync !== 1'b0 || dvp_vsync_n !== 1'b1 || dvp_href !== 1'b0 || dvp_data !== 8'h00) begin
            tests_failed++;
            $display("FAIL midrst_bus: got vs=%b vsn=%b href=%b data=%02h expected 0 1 0 00", dvp_vsync, dvp_vsync_n, dvp_href, dvp_data);
        end
        tests_run++;
        if (pix_ready !== 1'b0 || frame_start !== 1'b0 || frame_done !== 1'b0 || underflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_flags: got rdy=%b fs=%b fd=%b uf=%b expected all 0", pix_ready, frame_start, frame_done, underflow);
        end
        @(negedge clk);
        exp_q.delete();
        in_frame = 1'b0; advance = 1'b0; ready_cnt = 0; drop_slot = 0;
        pix_data = 16'h1357; pix_valid = 1'b1; enable = 1'b1;
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        tests_run++;
        if (frame_start !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst_restart: got fs=%b expected 1", frame_start);
        end
        for (int i = 0; i < FRAME_LEN + 5 && fd_at < 0; i++) begin
            if (frame_done) fd_at = i;
            else @(negedge clk);
        end
        tests_run++;
        if (fd_at != FRAME_LEN - 1) begin
            tests_failed++;
            $display("FAIL midrst_length: got frame_done at %0d expected %0d", fd_at, FRAME_LEN - 1);
        end
        enable = 1'b0;
        tests_run++;
        if (underflow !== 1'b0 || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL midrst_clean: got uf=%b pending=%0d expected 0 0", underflow, exp_q.size());
        end
        repeat (4) @(negedge clk);
        mon_en = 1'b0;
        $display("[TB] test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_frames();
        test_underflow();
        test_enable_stop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
